// File: rtl/core_dmem_ctrl.sv
// Data-memory controller between the core data port and a 1-cycle-latency byte-enabled SRAM.
// Define DMEM_RANGE_CHK_EN to enable word-address range checking and the err_o port.
module core_dmem_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int BE_WIDTH    = 4,
   parameter int WAIT_STATES = 0,
   parameter int MEM_DEPTH   = 16384
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_wr_i,
   input  logic [BE_WIDTH-1:0]   data_be_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0] data_rdata_o,
   output logic                  busy_o,
   output logic                  mem_en_o,
   output logic [BE_WIDTH-1:0]   mem_we_o,
   output logic [ADDR_WIDTH-3:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
`ifdef DMEM_RANGE_CHK_EN
   output logic                  err_o,
`endif
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

   localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

   state_t                  state, state_nxt;
   logic [2:0]              cnt, cnt_nxt;
   logic                    accept;
   logic                    in_access;
   logic [ADDR_WIDTH-3:0]   addr_q;
   logic                    wr_q;
   logic [BE_WIDTH-1:0]     be_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    err_q;
   logic                    unused_lsbs;

   // Byte offset is guaranteed zero by the core.
   assign unused_lsbs = ^data_addr_i[1:0];

   assign accept    = (state == ST_IDLE) && data_req_i && !rst;
   assign in_access = (state == ST_ACCESS);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (data_req_i) begin
               cnt_nxt   = WS_LOAD;
               state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            cnt_nxt = cnt - 3'd1;
            if (cnt <= 3'd1) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wr_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= data_addr_i[ADDR_WIDTH-1:2];
         wr_q    <= data_wr_i;
         be_q    <= data_be_i;
         wdata_q <= data_wdata_i;
      end
   end

`ifdef DMEM_RANGE_CHK_EN
   localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);
   logic [31:0] word_ext;
   assign word_ext = 32'(data_addr_i[ADDR_WIDTH-1:2]);

   // Out-of-range flag is captured with the request and rides along to completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
         err_o <= 1'b0;
      end else begin
         if (accept) err_q <= (word_ext >= DEPTH_U);
         err_o <= (state == ST_RESP) && err_q;
      end
   end
`else
   localparam int unused_depth = MEM_DEPTH;
   assign err_q = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
      end else begin
         data_rvalid_o <= (state == ST_RESP);
         if (state == ST_RESP) data_rdata_o <= (wr_q || err_q) ? '0 : mem_rdata_i;
      end
   end

   assign data_gnt_o  = accept;
   assign busy_o      = (state != ST_IDLE);
   assign mem_en_o    = in_access && !err_q;
   assign mem_we_o    = (in_access && !err_q && wr_q) ? be_q : '0;
   assign mem_addr_o  = in_access ? addr_q : '0;
   assign mem_wdata_o = in_access ? wdata_q : '0;

endmodule

// File: tb/tb_core_dmem_ctrl.sv
// Directed bench for core_dmem_ctrl: instance 0 has no wait states, instance 1 has three.
module tb_core_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req[2], wr[2], gnt[2], rvalid[2], busy[2], men[2];
   logic [17:0] addr[2];
   logic [3:0]  be[2], mwe[2];
   logic [31:0] wdata[2], rdata[2], mwdata[2], mrdata[2];
   logic [15:0] maddr[2];
`ifdef DMEM_RANGE_CHK_EN
   logic        err[2];
`endif
   logic [31:0] sram[2][256];
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   core_dmem_ctrl #(.ADDR_WIDTH(18), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .data_req_i(req[0]), .data_addr_i(addr[0]), .data_wr_i(wr[0]),
      .data_be_i(be[0]), .data_wdata_i(wdata[0]), .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]),
      .data_rdata_o(rdata[0]), .busy_o(busy[0]), .mem_en_o(men[0]), .mem_we_o(mwe[0]),
      .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]),
`ifdef DMEM_RANGE_CHK_EN
      .err_o(err[0]),
`endif
      .mem_rdata_i(mrdata[0]));

   core_dmem_ctrl #(.ADDR_WIDTH(18), .WAIT_STATES(3)) dut3 (
      .clk(clk), .rst(rst), .data_req_i(req[1]), .data_addr_i(addr[1]), .data_wr_i(wr[1]),
      .data_be_i(be[1]), .data_wdata_i(wdata[1]), .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]),
      .data_rdata_o(rdata[1]), .busy_o(busy[1]), .mem_en_o(men[1]), .mem_we_o(mwe[1]),
      .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]),
`ifdef DMEM_RANGE_CHK_EN
      .err_o(err[1]),
`endif
      .mem_rdata_i(mrdata[1]));

   // Synchronous SRAM model with byte writes and read-before-write.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (men[k]) begin
            for (int b = 0; b < 4; b++)
               if (mwe[k][b]) sram[k][maddr[k][7:0]][b*8 +: 8] <= mwdata[k][b*8 +: 8];
            mrdata[k] <= sram[k][maddr[k][7:0]];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One transaction on instance k; checks grant, latency, SRAM strobes and the response.
   task automatic xact(input int k, input logic w, input logic [17:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] exp_rd);
      int ws, acc_at, rv_at, n_acc, n_rv, gnt_bad, busy_bad, idle_bad;
      logic [31:0] rd_seen, wd_seen;
      logic [3:0]  we_seen;
      logic [15:0] ad_seen;
      logic        err_seen;
      ws = (k == 0) ? 0 : 3;
      acc_at = -1; rv_at = -1; n_acc = 0; n_rv = 0; gnt_bad = 0; busy_bad = 0; idle_bad = 0;
      rd_seen = 'x; wd_seen = 'x; we_seen = 'x; ad_seen = 'x; err_seen = 1'b0;
      @(posedge clk); #1;
      req[k] = 1'b1; wr[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
      @(negedge clk);
      chk("gnt", gnt[k], 1);
      chk("busy_at_gnt", busy[k], 0);
      @(posedge clk); #1;
      req[k] = 1'b0; wr[k] = ~w; addr[k] = ~a; be[k] = ~b; wdata[k] = ~d;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (men[k]) begin
            acc_at = c; n_acc++; we_seen = mwe[k]; ad_seen = maddr[k]; wd_seen = mwdata[k];
         end else if (mwe[k] != 0 || maddr[k] != 0 || mwdata[k] != 0) idle_bad++;
         if (rvalid[k]) begin
            rv_at = c; n_rv++; rd_seen = rdata[k];
`ifdef DMEM_RANGE_CHK_EN
            err_seen = err[k];
`endif
         end
         if (gnt[k]) gnt_bad++;
         if (busy[k] != (c <= 2 + ws)) busy_bad++;
      end
      chk("access_cycle", acc_at, 1 + ws);
      chk("rvalid_cycle", rv_at, 3 + ws);
      chk("access_count", n_acc, 1);
      chk("rvalid_count", n_rv, 1);
      chk("mem_addr", {16'h0, ad_seen}, {16'h0, a[17:2]});
      chk("mem_we", {28'h0, we_seen}, {28'h0, (w ? b : 4'h0)});
      chk("mem_wdata", wd_seen, d);
      chk("rdata", rd_seen, exp_rd);
      chk("rdata_hold", rdata[k], exp_rd);
      chk("gnt_busy", gnt_bad, 0);
      chk("busy_window", busy_bad, 0);
      chk("mem_idle_zero", idle_bad, 0);
      chk("err", {31'h0, err_seen}, 0);
   endtask

   initial begin
      int rv_at, n_rv;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req[k] = 0; wr[k] = 0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_gnt", gnt[k], 0);
         chk("rst_rvalid", rvalid[k], 0);
         chk("rst_rdata", rdata[k], 0);
         chk("rst_busy", busy[k], 0);
         chk("rst_men", men[k], 0);
         chk("rst_mwe", mwe[k], 0);
      end
      @(posedge clk); #1; rst = 1'b0;

      // No wait states: preload, read, byte store, read-modify check, empty store.
      xact(0, 1'b1, 18'h00040, 4'hF, 32'hDEADBEEF, 32'h0);
      xact(0, 1'b1, 18'h00044, 4'hF, 32'h11223344, 32'h0);
      xact(0, 1'b0, 18'h00040, 4'h0, 32'h0, 32'hDEADBEEF);
      xact(0, 1'b1, 18'h00044, 4'b0100, 32'h00AB0000, 32'h0);
      xact(0, 1'b0, 18'h00044, 4'h0, 32'h0, 32'h11AB3344);
      xact(0, 1'b1, 18'h00040, 4'h0, 32'hFFFFFFFF, 32'h0);
      xact(0, 1'b0, 18'h00040, 4'h0, 32'h0, 32'hDEADBEEF);

      // Back-to-back: second load requested in the first load's rvalid cycle.
      @(posedge clk); #1;
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 18'h00040; be[0] = 4'h0; wdata[0] = '0;
      @(negedge clk);
      chk("b2b_gnt1", gnt[0], 1);
      @(posedge clk); #1; req[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req[0] = 1'b1; addr[0] = 18'h00044;
      @(negedge clk);
      chk("b2b_rvalid1", rvalid[0], 1);
      chk("b2b_rdata1", rdata[0], 32'hDEADBEEF);
      chk("b2b_gnt2", gnt[0], 1);
      @(posedge clk); #1; req[0] = 1'b0;
      rv_at = -1; n_rv = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (rvalid[0]) begin
            n_rv++;
            if (rv_at < 0) rv_at = c;
         end
      end
      chk("b2b_rvalid2_cycle", rv_at, 3);
      chk("b2b_rvalid2_count", n_rv, 1);
      chk("b2b_rdata2", rdata[0], 32'h11AB3344);

`ifdef DMEM_RANGE_CHK_EN
      // Word index 0x4000 equals MEM_DEPTH: errored, SRAM untouched.
      @(posedge clk); #1;
      req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 18'h10000; be[0] = 4'hF; wdata[0] = 32'h12345678;
      @(negedge clk);
      chk("rng_gnt", gnt[0], 1);
      @(posedge clk); #1; req[0] = 1'b0;
      begin
         int n_en;
         logic e_seen;
         logic [31:0] r_seen;
         n_en = 0; rv_at = -1; e_seen = 1'b0; r_seen = 'x;
         for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (men[0] || mwe[0] != 0) n_en++;
            if (rvalid[0]) begin
               rv_at = c; e_seen = err[0]; r_seen = rdata[0];
            end
         end
         chk("rng_mem_en", n_en, 0);
         chk("rng_rvalid_cycle", rv_at, 3);
         chk("rng_err", {31'h0, e_seen}, 1);
         chk("rng_rdata", r_seen, 0);
         chk("rng_err_pulse", {31'h0, err[0]}, 0);
      end
      xact(0, 1'b0, 18'h00040, 4'h0, 32'h0, 32'hDEADBEEF);
`endif

      // Three wait states.
      xact(1, 1'b1, 18'h00080, 4'hF, 32'hCAFEF00D, 32'h0);
      xact(1, 1'b0, 18'h00080, 4'h0, 32'h0, 32'hCAFEF00D);

      // Reset during WAIT abandons the access.
      @(posedge clk); #1;
      req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 18'h00080;
      @(negedge clk);
      chk("rst_mid_gnt", gnt[1], 1);
      @(posedge clk); #1; req[1] = 1'b0;
      @(posedge clk); #2;
      chk("rst_mid_busy_before", busy[1], 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", busy[1], 0);
      chk("rst_mid_rvalid", rvalid[1], 0);
      chk("rst_mid_rdata", rdata[1], 0);
      chk("rst_mid_men", men[1], 0);
      chk("rst_mid_gnt0", gnt[1], 0);
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      n_rv = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (rvalid[1] || busy[1]) n_rv++;
      end
      chk("rst_mid_no_rvalid", n_rv, 0);
      xact(1, 1'b0, 18'h00080, 4'h0, 32'h0, 32'hCAFEF00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/core_dmem_ctrl.md
Name: core_dmem_ctrl

Overview:
Data-memory controller directly downstream of the core's memory stage. It consumes the core data port request (data_req/addr/wr/be/wdata) and returns the grant, read-valid and read data. It drives a single-port synchronous SRAM with byte write enables and 1-cycle read latency. A programmable wait-state count emulates slower memory.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_WIDTH, 16, byte address width from core
BE_WIDTH, 4, byte enables, DATA_WIDTH/8
WAIT_STATES, 0, extra cycles before SRAM access; legal 0..7
MEM_DEPTH, 16384, SRAM depth in words (range check only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
data_req_i  in  1  core request; held high until granted
data_addr_i  in  ADDR_WIDTH  byte address; word aligned
data_wr_i  in  1  1=store, 0=load
data_be_i  in  BE_WIDTH  byte lanes, already lane-aligned by core
data_wdata_i  in  DATA_WIDTH  store data, lane-aligned
data_gnt_o  out  1  request accepted this cycle (combinational)
data_rvalid_o  out  1  registered 1-cycle completion pulse (loads and stores)
data_rdata_o  out  DATA_WIDTH  registered full load word; 0 for stores
busy_o  out  1  state != IDLE
mem_en_o  out  1  SRAM enable, 1 cycle per access
mem_we_o  out  BE_WIDTH  SRAM byte write enables
mem_addr_o  out  ADDR_WIDTH-2  SRAM word address = addr[ADDR_WIDTH-1:2]
mem_wdata_o  out  DATA_WIDTH  SRAM write data
mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid cycle after mem_en_o
err_o  out  1  only with DMEM_RANGE_CHK_EN; qualifies data_rvalid_o

Behaviour:
- Reset (any time, async): state IDLE, wait counter 0, all outputs 0, latched request cleared; in-flight access abandoned, no rvalid issued.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: data_gnt_o = data_req_i. On req, latch addr/wr/be/wdata and load the 3-bit counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: counter decrements each cycle; leave for ACCESS in the cycle the counter reaches 1. This yields exactly WAIT_STATES WAIT cycles.
- ACCESS: mem_en_o=1, mem_addr_o from latch, mem_we_o = wr ? be : 0, mem_wdata_o from latch. Go to RESP.
- RESP: at clock edge, data_rvalid_o<=1 and data_rdata_o <= wr ? 0 : mem_rdata_i. Return to IDLE.
- data_rvalid_o pulses exactly one cycle, concurrent with the IDLE cycle after RESP. data_rdata_o holds its value until the next completion.
- Latency: grant at cycle T, ACCESS at T+1+WAIT_STATES, rvalid at T+3+WAIT_STATES.
- data_gnt_o is 0 in all non-IDLE states. The master keeps req and its inputs stable; inputs are ignored until granted.
- Back-to-back: a req in the rvalid cycle (IDLE) is granted that same cycle.
- mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o are 0 outside ACCESS.
- Store with be=0: mem_en_o still pulses with mem_we_o=0; completes normally.
- addr[1:0] ignored (the core guarantees alignment).
- One outstanding transaction maximum.

Optional Feature:
DMEM_RANGE_CHK_EN
- Defined: at grant, flag error if addr[ADDR_WIDTH-1:2] >= MEM_DEPTH. Errored accesses go through WAIT/ACCESS/RESP timing, but mem_en_o and mem_we_o stay 0 in ACCESS. At completion, data_rdata_o=0 and err_o=1 together with data_rvalid_o. err_o is a registered 1-cycle pulse, reset 0.
- Undefined: no check and no err_o port; word address passes unmodified (SRAM wraps).

Test Plan:
- Read, WAIT_STATES=0: SRAM[0x10]=0xDEADBEEF; req load addr 0x0040 at T -> gnt at T; mem_en_o=1, mem_addr_o=0x10 at T+1; rvalid=1, rdata=0xDEADBEEF at T+3 only.
- Byte store: SRAM[0x11]=0x11223344; store addr 0x0044, be=4'b0100, wdata=0x00AB0000 -> mem_we_o=4'b0100 in ACCESS, rvalid with rdata=0; reading 0x0044 back returns 0x11AB3344.
- Wait states: WAIT_STATES=3, load with req held high -> gnt only at T, busy_o=1 T+1..T+5, ACCESS at T+4, rvalid at T+6.
- Back-to-back: second load asserted during first rvalid cycle -> gnt that cycle, second rvalid exactly 3 cycles later (WAIT_STATES=0).
- Reset mid-op: WAIT_STATES=3, assert rst during WAIT -> all outputs 0 immediately, no rvalid after release; next request completes normally.
- Range check (macro on, MEM_DEPTH=16384): store to 0x10000 word index overflow via ADDR_WIDTH=18 -> mem_en_o=0, rvalid with err_o=1, rdata=0; in-range access gives err_o=0.
